// File: rtl/game_ctrl_pkg.sv
// Shared types and constants for the GameControl remainder-unit sequencer.
package game_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam int DEFAULT_TIMEOUT = 255;

    // Timer must be able to hold the value TIMEOUT itself.
    function automatic int timer_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mod_arbiter_rr_picker.sv
// Round-robin picker: rotate requests so last_grant+1 sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    output logic [IW-1:0]    grant_idx,
    output logic             any
);

    int                 start;
    int                 pos;
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;

    always_comb begin
        start = (int'(last_grant) + 1) % N_REQ;
        dbl   = {req, req};
        rot   = N_REQ'(dbl >> start);
        pos   = 0;
        any   = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = i;
                any = 1'b1;
            end
        end
        grant_idx = IW'((start + pos) % N_REQ);
    end

endmodule

// File: rtl/mod_arbiter.sv
// Shares one a_mod_b remainder unit among N_REQ requesters: round-robin grant,
// operand latch, start/done handshake, divide-by-zero and timeout trapping.
module mod_arbiter
    import game_ctrl_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = 7,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             interboard_rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0] ack,
    output logic [N_REQ-1:0] resp_valid,
    output logic [W-1:0]     resp_ans,
    output logic             resp_err,
    output logic             mod_start,
    output logic [W-1:0]     mod_a,
    output logic [W-1:0]     mod_b,
    input  logic             mod_ready,
    input  logic             mod_done,
    input  logic [W-1:0]     mod_ans
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = timer_w(TIMEOUT);
    localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);
    localparam logic [TW-1:0] T_LIMIT  = TW'(TIMEOUT - 1);

    state_t            state;
    state_t            nstate;
    logic              srst;
    logic [IW-1:0]     last_grant;
    logic [IW-1:0]     gidx;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [W-1:0]      pick_a;
    logic [W-1:0]      pick_b;
    logic [W-1:0]      lat_a;
    logic [W-1:0]      lat_b;
    logic [W-1:0]      ans_q;
    logic              err_q;
    logic [N_REQ-1:0]  ack_q;
    logic [TW-1:0]     timer;
    logic              expired;

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [N_REQ-1:0] v;
        for (int i = 0; i < N_REQ; i++) begin
            v[i] = (idx == IW'(i));
        end
        return v;
    endfunction

    assign srst    = rst | interboard_rst;
    assign expired = (timer == T_LIMIT);

    rr_picker #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant),
        .grant_idx  (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        pick_a = '0;
        pick_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_a = req_a[i*W +: W];
                pick_b = req_b[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state <= ST_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    nstate = (pick_b == '0) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (expired) begin
                    nstate = ST_RESP;
                end else if (mod_ready) begin
                    nstate = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mod_done || expired) begin
                    nstate = ST_RESP;
                end
            end
            ST_RESP: nstate = ST_IDLE;
            default: nstate = ST_IDLE;
        endcase
    end

    // Latches, timer and result registers; a done strobe only counts in WAIT.
    always_ff @(posedge clk) begin
        if (srst) begin
            last_grant <= LAST_RST;
            gidx       <= '0;
            lat_a      <= '0;
            lat_b      <= '0;
            ans_q      <= '0;
            err_q      <= 1'b0;
            ack_q      <= '0;
            timer      <= '0;
        end else begin
            ack_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gidx  <= pick_idx;
                        lat_a <= pick_a;
                        lat_b <= pick_b;
                        timer <= '0;
                        ack_q <= onehot(pick_idx);
                        ans_q <= '0;
                        err_q <= (pick_b == '0);
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    timer <= timer + TW'(1);
                    if (state == ST_WAIT && mod_done) begin
                        ans_q <= mod_ans;
                        err_q <= 1'b0;
                    end else if (expired) begin
                        ans_q <= '0;
                        err_q <= 1'b1;
                    end
                end
                ST_RESP: last_grant <= gidx;
                default: ;
            endcase
        end
    end

    always_comb begin
        ack        = ack_q;
        mod_a      = lat_a;
        mod_b      = lat_b;
        mod_start  = (state == ST_ISSUE) && mod_ready;
        resp_valid = '0;
        resp_ans   = '0;
        resp_err   = 1'b0;
        if (state == ST_RESP) begin
            resp_valid = onehot(gidx);
            resp_ans   = ans_q;
            resp_err   = err_q;
        end
    end

endmodule
